// File: rtl/ram4x4_arbiter.sv
// Two-port round-robin controller owning a DEPTH x DATA_W register bank.
// Each granted transaction runs IDLE -> SRV -> ACK, so accesses are fully serialized.
module ram4x4_arbiter #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              busy,
    output logic [1:0]        state_dbg
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SRV  = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Handshake: a requester raises req with we/addr/wdata and holds them until its
    // one-cycle ack pulse; req still high when IDLE returns starts a new transaction.
    state_t                          state_q, state_d;
    logic                            last_gnt_q, last_gnt_d;
    logic                            cmd_port_q, cmd_port_d;
    logic                            cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0]               cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]               cmd_wdata_q, cmd_wdata_d;
    logic [DEPTH-1:0][DATA_W-1:0]    mem_q, mem_d;
    logic [DATA_W-1:0]               a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]               b_rdata_q, b_rdata_d;
    logic                            a_ack_q, a_ack_d;
    logic                            b_ack_q, b_ack_d;
    logic                            busy_q, busy_d;
    logic [DEPTH-1:0]                word_we;
    logic                            grant_b;

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        cmd_port_d  = cmd_port_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        word_we     = '0;
        // On a tie the port that was not served last wins.
        grant_b     = b_req && (!a_req || (last_gnt_q == PORT_A));

        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    cmd_port_d  = grant_b;
                    cmd_we_d    = grant_b ? b_we    : a_we;
                    cmd_addr_d  = grant_b ? b_addr  : a_addr;
                    cmd_wdata_d = grant_b ? b_wdata : a_wdata;
                    last_gnt_d  = grant_b;
                    state_d     = SRV;
                end
            end
            SRV: begin
                if (cmd_we_q) begin
                    word_we[cmd_addr_q] = 1'b1;
                end else if (cmd_port_q == PORT_B) begin
                    b_rdata_d = mem_q[cmd_addr_q];
                end else begin
                    a_rdata_d = mem_q[cmd_addr_q];
                end
                a_ack_d = (cmd_port_q == PORT_A);
                b_ack_d = (cmd_port_q == PORT_B);
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = word_we[i] ? cmd_wdata_q : mem_q[i];
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= IDLE;
            last_gnt_q  <= PORT_B;
            cmd_port_q  <= PORT_A;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            mem_q       <= '0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            cmd_port_q  <= cmd_port_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            mem_q       <= mem_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ram4x4_arbiter.sv
// Bench for ram4x4_arbiter: transaction-level memory/arbitration model feeding an
// expected queue, popped by a monitor on every ack pulse.
module tb_ram4x4_arbiter;
    logic       clk = 1'b0;
    logic       clear_n;
    logic       req   [2];
    logic       we    [2];
    logic [1:0] addr  [2];
    logic [3:0] wdata [2];
    logic       ack   [2];
    logic [3:0] rdata [2];
    logic       busy;
    logic [1:0] state_dbg;

    ram4x4_arbiter dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .a_req     (req[0]),
        .a_we      (we[0]),
        .a_addr    (addr[0]),
        .a_wdata   (wdata[0]),
        .a_ack     (ack[0]),
        .a_rdata   (rdata[0]),
        .b_req     (req[1]),
        .b_we      (we[1]),
        .b_addr    (addr[1]),
        .b_wdata   (wdata[1]),
        .b_ack     (ack[1]),
        .b_rdata   (rdata[1]),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    int         errors = 0;
    int         checks = 0;
    bit         mon_en = 1'b0;
    logic [3:0] mem_m [4];
    logic [3:0] rd_m  [2];
    int         last_m;
    logic [3:0] shown [2];
    logic [4:0] exp_q [$];          // {port, expected rdata}
    int         exp_t_q [2][$];     // expected ack cycle per transaction
    logic [6:0] cmd_q [2][$];       // {we, addr, wdata}

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mem_m[i] = 4'h0;
        rd_m[0]  = 4'h0;
        rd_m[1]  = 4'h0;
        shown[0] = 4'h0;
        shown[1] = 4'h0;
        last_m   = 1;
        exp_q.delete();
    endtask

    task automatic clear_cmds();
        cmd_q[0].delete();
        cmd_q[1].delete();
    endtask

    // Serve pending commands one by one; ties go to the port not served last.
    task automatic model_round();
        int qi0, qi1, p, slot;
        logic [6:0] c;
        qi0 = 0; qi1 = 0; slot = 0;
        exp_t_q[0].delete();
        exp_t_q[1].delete();
        while (qi0 < cmd_q[0].size() || qi1 < cmd_q[1].size()) begin
            if (qi0 < cmd_q[0].size() && qi1 < cmd_q[1].size()) p = 1 - last_m;
            else if (qi0 < cmd_q[0].size()) p = 0;
            else p = 1;
            if (p == 0) begin c = cmd_q[0][qi0]; qi0++; end
            else        begin c = cmd_q[1][qi1]; qi1++; end
            if (c[6]) mem_m[c[5:4]] = c[3:0];
            else      rd_m[p] = mem_m[c[5:4]];
            exp_q.push_back({p[0], rd_m[p]});
            exp_t_q[p].push_back(2 + 3 * slot);
            slot++;
            last_m = p;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_port(input int p, input bit scramble);
        int n;
        bit got;
        logic [6:0] c;
        n = 0;
        for (int k = 0; k < cmd_q[p].size(); k++) begin
            c = cmd_q[p][k];
            we[p] = c[6]; addr[p] = c[5:4]; wdata[p] = c[3:0]; req[p] = 1'b1;
            got = 1'b0;
            while (!got && n < 60) begin
                @(posedge clk);
                n++;
                if (scramble && k == 0 && n == 1) begin
                    #1;
                    addr[p]  = addr[p] ^ 2'b10;
                    wdata[p] = ~wdata[p];
                end
                @(negedge clk);
                if (ack[p]) got = 1'b1;
            end
            chk($sformatf("ack_cycle_p%0d", p), n, exp_t_q[p][k]);
            if (got) chk("busy_in_ack", int'(busy), 1);
            @(posedge clk);
            n++;
            #1;
            if (k == cmd_q[p].size() - 1) begin
                req[p]   = 1'b0;
                we[p]    = 1'($urandom_range(0, 1));
                addr[p]  = 2'($urandom_range(0, 3));
                wdata[p] = 4'($urandom_range(0, 15));
            end
        end
    endtask

    task automatic run_round(input bit scr_req);
        bit scr;
        model_round();
        scr = scr_req && (exp_t_q[0].size() > 0) && (exp_t_q[0][0] == 2);
        fork
            drive_port(0, scr);
            drive_port(1, 1'b0);
        join
        clear_cmds();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [4:0] e;
        if (clear_n === 1'b1 && mon_en) begin
            if (ack[0] && ack[1]) chk("dual_ack", 1, 0);
            for (int p = 0; p < 2; p++) begin
                if (ack[p]) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("unexpected_ack_p%0d", p), 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_port", p, int'(e[4]));
                        chk($sformatf("rdata_p%0d", p), int'(rdata[p]), int'(e[3:0]));
                        shown[p] = e[3:0];
                    end
                end
            end
            chk("hold_rdata_a", int'(rdata[0]), int'(shown[0]));
            chk("hold_rdata_b", int'(rdata[1]), int'(shown[1]));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0] c;
        int na, nb;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; addr[p] = 2'd0; wdata[p] = 4'h0;
        end
        clear_cmds();
        clear_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ack", int'(ack[0]), 0);
        chk("rst_b_ack", int'(ack[1]), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_a_rdata", int'(rdata[0]), 0);
        chk("rst_b_rdata", int'(rdata[1]), 0);
        chk("rst_state", int'(state_dbg), 0);
        @(posedge clk);
        #3 clear_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of SRV of an A write 4'hF @1.
        we[0] = 1'b1; addr[0] = 2'd1; wdata[0] = 4'hF; req[0] = 1'b1;
        @(posedge clk);
        #3;
        chk("srv_busy", int'(busy), 1);
        clear_n = 1'b0;
        model_reset();
        #1;
        chk("abort_a_ack", int'(ack[0]), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_state", int'(state_dbg), 0);
        req[0] = 1'b0;
        @(negedge clk);
        chk("abort_a_ack_later", int'(ack[0]), 0);
        @(posedge clk);
        #3 clear_n = 1'b1;
        @(posedge clk);
        #1;

        // Tie straight after reset: A first, then B.
        cmd_q[0].push_back({1'b1, 2'd0, 4'h3});
        cmd_q[1].push_back({1'b1, 2'd0, 4'hC});
        run_round(1'b0);
        cmd_q[0].push_back({1'b0, 2'd0, 4'h0});
        run_round(1'b0);
        cmd_q[0].push_back({1'b0, 2'd1, 4'h0});
        run_round(1'b0);

        // Single port write then read.
        cmd_q[0].push_back({1'b1, 2'd2, 4'hA});
        run_round(1'b0);
        cmd_q[0].push_back({1'b0, 2'd2, 4'h0});
        run_round(1'b0);

        // Read isolation: B writes @3, then A reads @3 while B reads @1.
        cmd_q[1].push_back({1'b1, 2'd3, 4'h5});
        run_round(1'b0);
        cmd_q[0].push_back({1'b0, 2'd3, 4'h0});
        cmd_q[1].push_back({1'b0, 2'd1, 4'h0});
        run_round(1'b0);

        // Continuous requests from both ports for four transactions.
        cmd_q[0].push_back({1'b0, 2'd3, 4'h0});
        cmd_q[0].push_back({1'b1, 2'd1, 4'h9});
        cmd_q[1].push_back({1'b0, 2'd1, 4'h0});
        cmd_q[1].push_back({1'b0, 2'd1, 4'h0});
        run_round(1'b0);

        // Command inputs changed during SRV must not affect the access.
        cmd_q[0].push_back({1'b1, 2'd0, 4'h7});
        run_round(1'b1);
        cmd_q[0].push_back({1'b0, 2'd0, 4'h0});
        cmd_q[0].push_back({1'b0, 2'd2, 4'h0});
        run_round(1'b0);

        // Randomized rounds.
        for (int r = 0; r < 40; r++) begin
            na = $urandom_range(0, 2);
            nb = $urandom_range(0, 3);
            if (na + nb == 0) na = 1;
            for (int i = 0; i < na; i++) begin
                c = 7'($urandom_range(0, 127));
                cmd_q[0].push_back(c);
            end
            for (int i = 0; i < nb; i++) begin
                c = 7'($urandom_range(0, 127));
                cmd_q[1].push_back(c);
            end
            run_round(1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram4x4_arbiter.md
Name: ram4x4_arbiter

Overview:
- Two-requester controller that owns and shares a 4-word x 4-bit register-based memory bank.
- The bank is built from the team's 4-bit word-register storage, with per-word gated write enable.
- Serializes read/write transactions from ports A and B using round-robin priority and a req/ack handshake.
- Sits between two bus masters and the shared scratch storage of the guia12 memory datapath.

Parameters:
- DATA_W, 4, word width in bits.
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W words (4).

Ports:
- clk  input  1  single system clock, rising-edge active.
- clear_n  input  1  asynchronous active-low reset; one clock, async assert, active-low.
- a_req  input  1  port A transaction request.
- a_we  input  1  port A write (1) / read (0).
- a_addr  input  ADDR_W  port A word address.
- a_wdata  input  DATA_W  port A write data.
- a_ack  output  1  port A one-cycle completion pulse.
- a_rdata  output  DATA_W  port A read data.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as port A, for port B.
- busy  output  1  high while state != IDLE.

Behaviour:
- Reset (clear_n=0, asynchronous, any state):
  - All DEPTH words = 0; a_rdata = b_rdata = 0; a_ack = b_ack = 0; busy = 0.
  - State = IDLE; priority pointer last_gnt = B, so A wins the first tie.
  - Reset mid-transaction aborts it: no write, no ack.
- States: IDLE, SRV, ACK.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both req: grant the port != last_gnt.
  - On grant: latch we/addr/wdata of the winner into the command register; last_gnt <= winner; go to SRV.
- SRV, one cycle, busy = 1:
  - Write: mem[addr] <= wdata at the end of the cycle.
  - Read: winner's rdata <= mem[addr] at the end of the cycle.
  - Go to ACK.
- ACK, one cycle:
  - Winner's ack = 1; the other ack = 0.
  - Winner's rdata is valid here and held until that port's next read completes. Writes leave rdata unchanged.
  - Go to IDLE.
- Latency: req sampled in IDLE at edge k, SRV in cycle k+1, ack high in cycle k+2. Three cycles per transaction; the next grant is no earlier than the cycle after ACK.
- Requester rules:
  - Hold req, we, addr and wdata stable until ack.
  - Deassert req in the cycle after ack.
  - req still high when IDLE is re-entered counts as a new transaction.
- Commands are latched at grant; requester input changes during SRV/ACK have no effect.
- The losing requester keeps req high and is granted at the next IDLE. Round-robin guarantees service within 2 transactions.
- Transactions are fully serialized, so there are no memory write collisions. A read after a write to the same address returns the new value.
- Address decode covers all DEPTH words; no out-of-range case. Words not addressed are never modified.
- The ack outputs and rdata are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: pulse clear_n low mid-SRV of an A write of 4'hF to addr 1 -> ack stays 0, busy=0, and a later A read of addr 1 returns 4'h0.
- Single port: A writes 4'hA to addr 2, then reads addr 2 -> a_ack high exactly 2 cycles after req is sampled each time, a_rdata=4'hA, b_ack never high.
- Tie after reset: A and B both req in the same cycle (A writes 4'h3 @0, B writes 4'hC @0) -> A served first, then B. A final read of @0 returns 4'hC.
- Round-robin: A and B hold req continuously for 4 transactions -> ack order A, B, A, B; no port is ever acked twice in a row.
- Read isolation: B writes 4'h5 @3, A reads @3 while B reads @1 (holds 0) -> a_rdata=4'h5, b_rdata=4'h0, and each rdata holds across the other port's transactions.
- Input change: A req with addr 0, addr switched to 2 during SRV -> access uses addr 0.
